// File: rtl/fir_tdm_filter_if.sv
// Frame handshake, coefficient-load port and result bus of the TDM FIR filter.
// The upstream/testbench side uses master; the filter uses slave.
interface fir_tdm_filter_if #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NUM_TAPS = 33,
  parameter int NUM_CH   = 2
);
  localparam int AW = $clog2(NUM_TAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     bypass;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic [COEF_W-1:0]        coef_wdata;
  logic                     out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_sat;

  modport master (
    output in_valid, in_data, bypass, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, bypass, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_tdm_filter.sv
// Multi-channel FIR with one shared MAC, a loadable coefficient bank shared by all
// channels, round-half-up scaling and per-channel saturation.
module fir_tdm_filter #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NUM_TAPS = 33,
  parameter int NUM_CH   = 2,
  parameter int SHIFT    = 15,
  parameter int ACC_W    = 40
) (
  input logic             clk,
  input logic             rst,
  fir_tdm_filter_if.slave bus
);
  localparam int AW = $clog2(NUM_TAPS);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = DATA_W + COEF_W;
  localparam int SW = ACC_W + 1;

  localparam logic [AW-1:0] LAST_TAP = AW'(NUM_TAPS - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

  localparam longint UNITY    = (longint'(1) <<< SHIFT) - 1;
  localparam longint COEF_MAX = (longint'(1) <<< (COEF_W - 1)) - 1;
  localparam logic signed [COEF_W-1:0] COEF0 = COEF_W'((UNITY > COEF_MAX) ? COEF_MAX : UNITY);

  localparam logic signed [SW-1:0] RND     = SW'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [SW-1:0] OUT_MAX = SW'((longint'(1) <<< (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] OUT_MIN = SW'(-(longint'(1) <<< (DATA_W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
  state_t state_q, state_d;

  logic [AW-1:0]            wp;
  logic [AW-1:0]            tap;
  logic [CW-1:0]            ch;
  logic                     issuing;
  logic                     byp_q;

  logic signed [PW-1:0]     prod_q, prod_d;
  logic                     p_vld, p_last;
  logic [CW-1:0]            p_ch;
  logic signed [ACC_W-1:0]  acc_q;

  logic signed [DATA_W-1:0] hist [NUM_CH][NUM_TAPS];
  logic signed [COEF_W-1:0] coef [NUM_TAPS];
  logic signed [DATA_W-1:0] res_q [NUM_CH];
  logic [NUM_CH-1:0]        sat_q;

  logic                     pend_we;
  logic [AW-1:0]            pend_addr;
  logic signed [COEF_W-1:0] pend_data;

  logic                     out_valid_q;
  logic [NUM_CH*DATA_W-1:0] out_data_q;
  logic [NUM_CH-1:0]        out_sat_q;

  logic                     idle, accept;
  logic [AW-1:0]            rd_idx;
  logic signed [DATA_W-1:0] sample;
  logic signed [SW-1:0]     sum, shifted;
  logic signed [DATA_W-1:0] res_d;
  logic                     sat_hit;

  assign idle          = (state_q == S_IDLE);
  assign accept        = idle && bus.in_valid;
  assign bus.in_ready  = idle;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_MAC;
      S_MAC:   if (p_vld && p_last && (p_ch == LAST_CH)) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tap k reads the sample written k frames ago; modulo arithmetic in AW bits
  // stays exact because the true index is always below NUM_TAPS.
  always_comb begin
    rd_idx = (wp >= tap) ? (wp - tap) : (wp - tap + AW'(NUM_TAPS));
    sample = hist[ch][rd_idx];
    prod_d = PW'(sample) * PW'(coef[tap]);
  end

  always_comb begin
    sum     = SW'(acc_q) + SW'(prod_q);
    shifted = (sum + RND) >>> SHIFT;
    res_d   = shifted[DATA_W-1:0];
    sat_hit = 1'b0;
    if (shifted > OUT_MAX) begin
      res_d   = OUT_MAX[DATA_W-1:0];
      sat_hit = 1'b1;
    end else if (shifted < OUT_MIN) begin
      res_d   = OUT_MIN[DATA_W-1:0];
      sat_hit = 1'b1;
    end
  end

  // NOTE: the delay lines sit in flops with a reset because a reset must clear
  // filter history; a RAM could not be cleared in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_TAPS; k++) hist[c][k] <= '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CH; c++) hist[c][wp] <= bus.in_data[c*DATA_W +: DATA_W];
    end
  end

  // A write coinciding with acceptance is parked so the frame just started keeps
  // the old bank; it lands on the OUT cycle, before the next frame can start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) coef[k] <= (k == 0) ? COEF0 : '0;
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      if (idle && bus.coef_we && (bus.coef_addr <= LAST_TAP)) begin
        if (bus.in_valid) begin
          pend_we   <= 1'b1;
          pend_addr <= bus.coef_addr;
          pend_data <= bus.coef_wdata;
        end else begin
          coef[bus.coef_addr] <= bus.coef_wdata;
        end
      end
      if ((state_q == S_OUT) && pend_we) begin
        coef[pend_addr] <= pend_data;
        pend_we         <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap     <= '0;
      ch      <= '0;
      issuing <= 1'b0;
      byp_q   <= 1'b0;
      prod_q  <= '0;
      p_vld   <= 1'b0;
      p_last  <= 1'b0;
      p_ch    <= '0;
      acc_q   <= '0;
      sat_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) res_q[c] <= '0;
    end else begin
      p_vld <= issuing;
      if (accept) begin
        tap     <= '0;
        ch      <= '0;
        issuing <= 1'b1;
        byp_q   <= bus.bypass;
        acc_q   <= '0;
      end
      if (issuing) begin
        prod_q <= prod_d;
        p_last <= (tap == LAST_TAP);
        p_ch   <= ch;
        if (tap == LAST_TAP) begin
          tap <= '0;
          if (ch == LAST_CH) issuing <= 1'b0;
          else               ch      <= ch + CW'(1);
        end else begin
          tap <= tap + AW'(1);
        end
      end
      if (p_vld) begin
        if (p_last) begin
          res_q[p_ch] <= res_d;
          sat_q[p_ch] <= sat_hit;
          acc_q       <= '0;
        end else begin
          acc_q <= sum[ACC_W-1:0];
        end
      end
    end
  end

  // Bypass frames are read back from the slot just written, since wp has not moved yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      wp          <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == S_OUT) begin
        out_valid_q <= 1'b1;
        for (int c = 0; c < NUM_CH; c++)
          out_data_q[c*DATA_W +: DATA_W] <= byp_q ? hist[c][wp] : res_q[c];
        out_sat_q <= byp_q ? '0 : sat_q;
        wp        <= (wp == LAST_TAP) ? '0 : wp + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fir_tdm_filter.sv
// Bench for fir_tdm_filter: directed scenarios with hand-computed results plus
// random traffic, all checked every cycle against a shift-register FIR model.
`timescale 1ns/1ps
module tb_fir_tdm_filter;
  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int NUM_TAPS = 33;
  localparam int NUM_CH   = 2;
  localparam int SHIFT    = 15;
  localparam int ACC_W    = 40;
  localparam int AW       = $clog2(NUM_TAPS);
  localparam int LAT      = NUM_CH * NUM_TAPS + 2;
  localparam int FW       = NUM_CH * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_tdm_filter_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS), .NUM_CH(NUM_CH)) bus ();

  fir_tdm_filter #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS),
    .NUM_CH(NUM_CH), .SHIFT(SHIFT), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_acc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model: newest sample at index 0 ----------------
  typedef struct {
    int                 due;
    logic [FW-1:0]      data;
    logic [NUM_CH-1:0]  sat;
  } exp_t;

  longint            m_coef [NUM_TAPS];
  longint            m_hist [NUM_CH][NUM_TAPS];
  exp_t              q [$];
  logic [FW-1:0]     m_last_data;
  logic [NUM_CH-1:0] m_last_sat;

  function automatic void model_reset();
    for (int k = 0; k < NUM_TAPS; k++) begin
      m_coef[k] = (k == 0) ? 32767 : 0;
      for (int c = 0; c < NUM_CH; c++) m_hist[c][k] = 0;
    end
    q.delete();
    m_last_data = '0;
    m_last_sat  = '0;
  endfunction

  function automatic void model_frame(input logic [FW-1:0] din, input logic byp,
                                      output logic [FW-1:0] dout, output logic [NUM_CH-1:0] sout);
    longint acc, r;
    logic signed [DATA_W-1:0] x;
    dout = '0;
    sout = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = NUM_TAPS - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      x = din[c*DATA_W +: DATA_W];
      m_hist[c][0] = longint'(x);
      acc = 0;
      for (int k = 0; k < NUM_TAPS; k++) acc += m_coef[k] * m_hist[c][k];
      r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      if (r > 32767)       begin r = 32767;  sout[c] = 1'b1; end
      else if (r < -32768) begin r = -32768; sout[c] = 1'b1; end
      dout[c*DATA_W +: DATA_W] = DATA_W'(r);
      if (byp) begin
        dout[c*DATA_W +: DATA_W] = din[c*DATA_W +: DATA_W];
        sout[c] = 1'b0;
      end
    end
  endfunction

  // ---------------- per-cycle compare process ----------------
  exp_t mon_e;
  logic exp_v, exp_r;
  logic signed [COEF_W-1:0] mon_c;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_sat", bus.out_sat, 0);
      model_reset();
    end else begin
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check("out_valid", bus.out_valid, exp_v);
      if (exp_v) begin
        m_last_data = q[0].data;
        m_last_sat  = q[0].sat;
        void'(q.pop_front());
      end
      check("out_data", bus.out_data, m_last_data);
      check("out_sat", bus.out_sat, m_last_sat);
      exp_r = (q.size() == 0);
      check("in_ready", bus.in_ready, exp_r);
      if (exp_r && bus.in_valid) begin
        model_frame(bus.in_data, bus.bypass, mon_e.data, mon_e.sat);
        mon_e.due = cyc + 1 + LAT;
        q.push_back(mon_e);
      end
      if (exp_r && bus.coef_we && (bus.coef_addr < NUM_TAPS)) begin
        mon_c = bus.coef_wdata;
        m_coef[bus.coef_addr] = longint'(mon_c);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int val);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(addr);
    bus.coef_wdata = COEF_W'(val);
    @(posedge clk); #1 bus.coef_we = 1'b0;
  endtask

  task automatic send(input int a, input int b, input logic byp);
    int n = 0;
    bus.in_data  = {DATA_W'(b), DATA_W'(a)};
    bus.bypass   = byp;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 400) begin @(negedge clk); n++; end
    check("send_ready_wait", bus.in_ready, 1);
    t_acc = cyc + 1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.bypass   = 1'b0;
  endtask

  task automatic wait_out(output logic [FW-1:0] d, output logic [NUM_CH-1:0] s, output int te);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 400);
    check("out_valid_wait", bus.out_valid, 1);
    d  = bus.out_data;
    s  = bus.out_sat;
    te = cyc;
    @(posedge clk); #1;
  endtask

  logic [FW-1:0]     d;
  logic [NUM_CH-1:0] s;
  int                te, n_acc, n_ov;
  logic signed [12:0] small_c;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.bypass = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset coefficients: near-unity pass-through at the full latency.
    send(1000, -1000, 1'b0);
    wait_out(d, s, te);
    check("t1_latency", te - t_acc, LAT);
    check("t1_ch0", $signed(d[15:0]), 1000);
    check("t1_ch1", $signed(d[31:16]), -1000);
    check("t1_sat", s, 0);
    check("t1_ready", bus.in_ready, 1);

    // Four taps of 0.25: step response ramps over four frames.
    do_reset();
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, (k < 4) ? 8192 : 0);
    for (int i = 0; i < 6; i++) begin
      send(4000, 0, 1'b0);
      wait_out(d, s, te);
      check("t2_ch0", $signed(d[15:0]), 1000 * ((i < 3) ? i + 1 : 4));
      check("t2_ch1", $signed(d[31:16]), 0);
    end

    // Saturation at both rails.
    do_reset();
    write_coef(0, 32767);
    write_coef(1, 32767);
    send(30000, 0, 1'b0);  wait_out(d, s, te);
    check("t3_pos1", $signed(d[15:0]), 29999);
    check("t3_pos1_sat", s, 0);
    send(30000, 0, 1'b0);  wait_out(d, s, te);
    check("t3_pos2", $signed(d[15:0]), 32767);
    check("t3_pos2_sat", s, 1);
    send(-32768, 0, 1'b0); wait_out(d, s, te);
    check("t3_neg1", $signed(d[15:0]), -2768);
    send(-32768, 0, 1'b0); wait_out(d, s, te);
    check("t3_neg2", $signed(d[15:0]), -32768);
    check("t3_neg2_sat", s, 1);

    // in_valid held for 200 cycles; a coefficient write while busy is dropped.
    do_reset();
    n_acc = 0;
    bus.in_data  = {16'sd0, 16'sd1000};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) n_acc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("t4_accepts", n_acc, 3);
    wait_out(d, s, te);
    send(1000, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1 write_coef(0, 0);
    wait_out(d, s, te);
    send(1000, 0, 1'b0);
    wait_out(d, s, te);
    check("t4_busy_write_dropped", $signed(d[15:0]), 1000);

    // Bypass passes the frame through but still feeds history.
    do_reset();
    write_coef(1, 16384);
    send(123, -456, 1'b1);
    wait_out(d, s, te);
    check("t5_latency", te - t_acc, LAT);
    check("t5_ch0", $signed(d[15:0]), 123);
    check("t5_ch1", $signed(d[31:16]), -456);
    check("t5_sat", s, 0);
    send(0, 0, 1'b0);
    wait_out(d, s, te);
    check("t5_hist_ch0", $signed(d[15:0]), 62);
    check("t5_hist_ch1", $signed(d[31:16]), -228);

    // Reset mid-MAC: frame aborted and history cleared.
    do_reset();
    write_coef(1, 32767);
    send(5000, 5000, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_ov = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) n_ov++;
    end
    check("t6_no_out_valid", n_ov, 0);
    check("t6_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    write_coef(1, 32767);
    send(1000, 0, 1'b0);
    wait_out(d, s, te);
    check("t6_impulse", $signed(d[15:0]), 1000);

    // Random traffic, checked by the per-cycle model compare.
    for (int i = 0; i < 4000; i++) begin
      bus.in_valid = ($urandom_range(0, 3) == 0);
      bus.in_data  = FW'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) bus.in_data = {16'sh8000, 16'sh7fff};
      bus.bypass   = ($urandom_range(0, 7) == 0);
      bus.coef_we  = ($urandom_range(0, 7) == 0);
      bus.coef_addr = AW'($urandom_range(0, NUM_TAPS - 1));
      small_c = 13'($urandom);
      bus.coef_wdata = ($urandom_range(0, 3) == 0) ? COEF_W'($urandom) : COEF_W'(small_c);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    bus.bypass   = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 400) begin @(negedge clk); n++; end
      check("drain_ready", bus.in_ready, 1);
    end
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
